// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI slave receiver:
//   state_t             - receiver FSM states (IDLE, SHIFT)
//   DEFAULT_DATA_WIDTH  - default received word width in bits
//   SYNC_DEPTH          - number of flops in each input synchronizer
// ---------------------------------------------------------------------------
package spi_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DEFAULT_DATA_WIDTH = 12;
    localparam int SYNC_DEPTH         = 2;

endpackage

// File: rtl/spi_sync.sv
// ---------------------------------------------------------------------------
// spi_sync
// Single-bit multi-flop synchronizer bringing an asynchronous SPI pin into
// the clk domain. Depth comes from spi_pkg::SYNC_DEPTH.
// Parameters:
//   RESET_VALUE - value every stage takes while rst is low
// Ports:
//   clk  in   system clock
//   rst  in   asynchronous active-low reset
//   d    in   asynchronous input pin
//   q    out  synchronized copy of d
// ---------------------------------------------------------------------------
module spi_sync
    import spi_pkg::*;
#(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_DEPTH-1:0] stages;

    // Plain shift chain; the last stage is the only one safe to use.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stages <= {SYNC_DEPTH{RESET_VALUE}};
        end else begin
            stages <= {stages[SYNC_DEPTH-2:0], d};
        end
    end

    assign q = stages[SYNC_DEPTH-1];

endmodule

// File: rtl/spi_slave_rx.sv
// ---------------------------------------------------------------------------
// spi_slave_rx
// SPI mode-0 slave receiver. sck/ssel/mosi are oversampled by clk (sck up to
// clk/8), words are shifted in MSB first and handed out on a valid/ready
// interface. Several words may follow each other in one ssel-low frame.
//
// Optional feature (macro SPI_RX_ECHO_EN): a transmit register echoes the
// current rx_data back on miso, MSB first, shifted on falling sck edges.
// Without the macro miso is tied low.
//
// Parameters:
//   DATA_WIDTH  received word width, 2..32
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-low reset
//   sck        in   SPI clock (idle low, sample on rising edge)
//   ssel       in   active-low slave select
//   mosi       in   serial data in, MSB first
//   miso       out  serial data out (echo feature) or 0
//   rx_data    out  last completed word
//   rx_valid   out  rx_data holds an unconsumed word
//   rx_ready   in   consumer accepts rx_data when high with rx_valid
//   overrun    out  sticky: a completed word was dropped
//   frame_err  out  one-clk pulse: frame ended mid-word
// ---------------------------------------------------------------------------
module spi_slave_rx
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sck,
    input  logic                  ssel,
    input  logic                  mosi,
    output logic                  miso,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  overrun,
    output logic                  frame_err
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    logic                  sck_s;
    logic                  ssel_s;
    logic                  mosi_s;
    logic                  sck_hist;
    logic                  sck_rise;
    state_t                state;
    state_t                next_state;
    logic [SYNC_DEPTH-1:0] settle;
    logic                  armed;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] shifted;
    logic [CW-1:0]         bit_cnt;
    logic                  word_done;
    logic [DATA_WIDTH-1:0] word_buf;
    logic                  enter_shift;
    logic                  in_frame;

    spi_sync #(.RESET_VALUE(1'b0)) u_sync_sck (
        .clk (clk),
        .rst (rst),
        .d   (sck),
        .q   (sck_s)
    );

    spi_sync #(.RESET_VALUE(1'b1)) u_sync_ssel (
        .clk (clk),
        .rst (rst),
        .d   (ssel),
        .q   (ssel_s)
    );

    spi_sync #(.RESET_VALUE(1'b0)) u_sync_mosi (
        .clk (clk),
        .rst (rst),
        .d   (mosi),
        .q   (mosi_s)
    );

    // History flop for sck edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sck_hist <= 1'b0;
        end else begin
            sck_hist <= sck_s;
        end
    end

    assign sck_rise = sck_s & ~sck_hist;

    // The synchronizers hold their reset values for SYNC_DEPTH clocks after
    // reset, so ssel_s only reflects the pin once settle is full. A frame may
    // start only after a genuine ssel-high has been seen; this stops a reset
    // in the middle of a frame from resuming that frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            settle <= '0;
            armed  <= 1'b0;
        end else begin
            settle <= {settle[SYNC_DEPTH-2:0], 1'b1};
            if (settle[SYNC_DEPTH-1] && ssel_s) begin
                armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (armed && !ssel_s) next_state = SHIFT;
            SHIFT:   if (ssel_s)           next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign enter_shift = (state == IDLE) && (next_state == SHIFT);
    assign in_frame    = (state == SHIFT) && !ssel_s;
    assign shifted     = {shift_reg[DATA_WIDTH-2:0], mosi_s};

    // Shift register and bit counter. A completed word is parked in
    // word_buf with a one-clk word_done strobe for the output stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            word_done <= 1'b0;
            word_buf  <= '0;
            frame_err <= 1'b0;
        end else begin
            word_done <= 1'b0;
            frame_err <= 1'b0;
            if (enter_shift) begin
                shift_reg <= '0;
                bit_cnt   <= '0;
            end else if (in_frame) begin
                if (sck_rise) begin
                    shift_reg <= shifted;
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt   <= '0;
                        word_done <= 1'b1;
                        word_buf  <= shifted;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
            end else if (state == SHIFT) begin
                frame_err <= (bit_cnt != '0);
                shift_reg <= '0;
                bit_cnt   <= '0;
            end
        end
    end

    // Output handshake: a new word is taken if the slot is free or being
    // drained this cycle, otherwise it is dropped and overrun latches.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (word_done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= word_buf;
                    rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

`ifdef SPI_RX_ECHO_EN
    logic                  sck_fall;
    logic [DATA_WIDTH-1:0] tx_reg;

    assign sck_fall = ~sck_s & sck_hist;

    // Echo register. A falling edge with bit_cnt at zero lies between two
    // words, so it reloads instead of shifting; the first word of a frame is
    // loaded on frame entry because no falling edge precedes its first bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_reg <= '0;
        end else if (enter_shift) begin
            tx_reg <= rx_data;
        end else if (in_frame && sck_fall) begin
            if (bit_cnt == '0) begin
                tx_reg <= rx_data;
            end else begin
                tx_reg <= {tx_reg[DATA_WIDTH-2:0], 1'b0};
            end
        end
    end

    assign miso = (state == SHIFT) ? tx_reg[DATA_WIDTH-1] : 1'b0;
`else
    assign miso = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_rx.sv
// ---------------------------------------------------------------------------
// tb_spi_slave_rx
// Directed bench for spi_slave_rx (DATA_WIDTH = 12). Drives SPI frames at
// clk/8 and compares outputs with hand-computed values. The expected miso
// sequence follows SPI_RX_ECHO_EN when the bench is built with it.
// ---------------------------------------------------------------------------
module tb_spi_slave_rx;

`ifdef SPI_RX_ECHO_EN
    localparam bit ECHO = 1'b1;
`else
    localparam bit ECHO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sck = 1'b0;
    logic        ssel = 1'b1;
    logic        mosi = 1'b0;
    logic        rx_ready = 1'b0;
    logic        miso;
    logic [11:0] rx_data;
    logic        rx_valid;
    logic        overrun;
    logic        frame_err;

    int          vectors = 0;
    int          miscompares = 0;
    int          valid_cycles = 0;
    int          fe_pulses = 0;
    logic [11:0] seen_data = '0;

    spi_slave_rx #(.DATA_WIDTH(12)) dut (
        .clk       (clk),
        .rst       (rst),
        .sck       (sck),
        .ssel      (ssel),
        .mosi      (mosi),
        .miso      (miso),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .overrun   (overrun),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    // Counts rx_valid and frame_err cycles, sampled 1ns after each edge.
    always begin
        @(posedge clk);
        #1;
        if (rx_valid) begin
            valid_cycles++;
            seen_data = rx_data;
        end
        if (frame_err) begin
            fe_pulses++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic waitClocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clearMonitor();
        valid_cycles = 0;
        fe_pulses    = 0;
    endtask

    task automatic frameStart();
        ssel = 1'b0;
        waitClocks(8);
    endtask

    task automatic frameEnd();
        waitClocks(4);
        ssel = 1'b1;
        waitClocks(12);
    endtask

    // Sends the low nbits of word MSB first, 4 clk low / 4 clk high per bit.
    // When check_miso is set, miso is compared just before each rising edge.
    task automatic applyStimulus(input logic [31:0] word, input int nbits,
                                 input logic check_miso, input logic [31:0] miso_word,
                                 input string tag);
        logic exp_bit;
        for (int i = nbits - 1; i >= 0; i--) begin
            mosi = word[i];
            waitClocks(4);
            if (check_miso) begin
                exp_bit = ECHO ? miso_word[i] : 1'b0;
                checkOutput($sformatf("%s_miso_b%0d", tag, i), {31'b0, miso}, {31'b0, exp_bit});
            end
            sck = 1'b1;
            waitClocks(4);
            sck = 1'b0;
        end
        mosi = 1'b0;
    endtask

    task automatic pulseReset();
        rst = 1'b0;
        waitClocks(3);
        rst = 1'b1;
        waitClocks(6);
    endtask

    initial begin
        $display("[TB] start, echo=%0d", ECHO);
        waitClocks(3);
        checkOutput("rst_rx_data", {20'b0, rx_data}, 32'h0);
        checkOutput("rst_rx_valid", {31'b0, rx_valid}, 32'h0);
        checkOutput("rst_overrun", {31'b0, overrun}, 32'h0);
        checkOutput("rst_frame_err", {31'b0, frame_err}, 32'h0);
        checkOutput("rst_miso", {31'b0, miso}, 32'h0);
        rst = 1'b1;
        waitClocks(6);

        // Single word, consumer always ready.
        rx_ready = 1'b1;
        clearMonitor();
        frameStart();
        applyStimulus(32'h82A, 12, 1'b0, 32'h0, "a");
        waitClocks(10);
        checkOutput("a_data", {20'b0, seen_data}, 32'h82A);
        checkOutput("a_valid_cycles", valid_cycles, 32'd1);
        checkOutput("a_overrun", {31'b0, overrun}, 32'h0);
        frameEnd();
        checkOutput("a_frame_err", fe_pulses, 32'd0);
        checkOutput("a_valid_clear", {31'b0, rx_valid}, 32'h0);

        // Two words back to back, consumer stalled.
        rx_ready = 1'b0;
        clearMonitor();
        frameStart();
        applyStimulus(32'h123, 12, 1'b0, 32'h0, "b1");
        applyStimulus(32'hABC, 12, 1'b0, 32'h0, "b2");
        waitClocks(10);
        checkOutput("b_data", {20'b0, rx_data}, 32'h123);
        checkOutput("b_valid", {31'b0, rx_valid}, 32'h1);
        checkOutput("b_overrun", {31'b0, overrun}, 32'h1);
        frameEnd();
        checkOutput("b_frame_err", fe_pulses, 32'd0);
        rx_ready = 1'b1;
        waitClocks(1);
        checkOutput("b_drained", {31'b0, rx_valid}, 32'h0);
        checkOutput("b_overrun_sticky", {31'b0, overrun}, 32'h1);
        rst = 1'b0;
        waitClocks(2);
        checkOutput("b_overrun_reset", {31'b0, overrun}, 32'h0);
        rst = 1'b1;
        waitClocks(6);

        // Frame aborted after 5 bits, then a good frame.
        clearMonitor();
        frameStart();
        applyStimulus(32'h15, 5, 1'b0, 32'h0, "c1");
        frameEnd();
        checkOutput("c_frame_err", fe_pulses, 32'd1);
        checkOutput("c_no_valid", valid_cycles, 32'd0);
        clearMonitor();
        frameStart();
        applyStimulus(32'hFFF, 12, 1'b0, 32'h0, "c2");
        waitClocks(10);
        frameEnd();
        checkOutput("c_data", {20'b0, seen_data}, 32'hFFF);
        checkOutput("c_valid_cycles", valid_cycles, 32'd1);
        checkOutput("c_frame_err2", fe_pulses, 32'd0);

        // Reset in mid-frame after 7 bits of 0x555.
        frameStart();
        applyStimulus(32'h555 >> 5, 7, 1'b0, 32'h0, "d1");
        rst = 1'b0;
        #1;
        checkOutput("d_rx_data", {20'b0, rx_data}, 32'h0);
        checkOutput("d_rx_valid", {31'b0, rx_valid}, 32'h0);
        checkOutput("d_overrun", {31'b0, overrun}, 32'h0);
        checkOutput("d_frame_err", {31'b0, frame_err}, 32'h0);
        checkOutput("d_miso", {31'b0, miso}, 32'h0);
        waitClocks(3);
        rst = 1'b1;
        waitClocks(8);
        // ssel is still low: these bits must be ignored entirely.
        clearMonitor();
        applyStimulus(32'h1F, 5, 1'b0, 32'h0, "d2");
        frameEnd();
        checkOutput("d_ignored_fe", fe_pulses, 32'd0);
        checkOutput("d_ignored_valid", valid_cycles, 32'd0);
        clearMonitor();
        frameStart();
        applyStimulus(32'h0F0, 12, 1'b0, 32'h0, "d3");
        waitClocks(10);
        frameEnd();
        checkOutput("d_data", {20'b0, seen_data}, 32'h0F0);
        checkOutput("d_rx_data_hold", {20'b0, rx_data}, 32'h0F0);

        // Echo: after reset rx_data is 0, then 0x82A comes back out on miso.
        pulseReset();
        frameStart();
        applyStimulus(32'h82A, 12, 1'b1, 32'h0, "e1");
        frameEnd();
        checkOutput("e_idle_miso", {31'b0, miso}, 32'h0);
        checkOutput("e_rx_data", {20'b0, rx_data}, 32'h82A);
        frameStart();
        applyStimulus(32'h000, 12, 1'b1, 32'h82A, "e2");
        frameEnd();
        checkOutput("e_rx_data2", {20'b0, rx_data}, 32'h000);
        checkOutput("e_idle_miso2", {31'b0, miso}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
